// File: rtl/reg_alu_sequencer.sv
// rtl/reg_alu_sequencer.sv - operand-fetch / execute / write-back sequencer around a 1R1W register bank
module reg_alu_sequencer #(
   parameter int DW = 8,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    in_op,
   input  logic [AW-1:0] in_rd,
   input  logic [AW-1:0] in_rs1,
   input  logic [AW-1:0] in_rs2,
   input  logic [DW-1:0] in_imm,
   output logic [AW-1:0] rb_addr_R,
   output logic [AW-1:0] rb_addr_W,
   output logic          rb_ld,
   output logic [DW-1:0] rb_in,
   input  logic [DW-1:0] rb_out,
   output logic          done,
   output logic [DW-1:0] result,
   output logic          flag_z,
   output logic          flag_c
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_LDI = 3'b101;
   localparam logic [2:0] OP_MOV = 3'b110;
   localparam logic [2:0] OP_NOP = 3'b111;

   typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXE, WB} state_t;

   state_t        state;
   logic [2:0]    op_q;
   logic [AW-1:0] rd_q, rs2_q;
   logic [DW-1:0] imm_q, opa_q, res_q;
   logic          c_q;
   logic [DW-1:0] alu_res;
   logic          alu_c;

   // B comes straight from the bank's read register during EXE.
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      case (op_q)
         OP_ADD:  {alu_c, alu_res} = {1'b0, opa_q} + {1'b0, rb_out};
         OP_SUB:  {alu_c, alu_res} = {1'b0, opa_q} - {1'b0, rb_out};
         OP_AND:  alu_res = opa_q & rb_out;
         OP_OR:   alu_res = opa_q | rb_out;
         OP_XOR:  alu_res = opa_q ^ rb_out;
         OP_LDI:  alu_res = imm_q;
         OP_MOV:  alu_res = opa_q;
         default: alu_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         rb_ld     <= 1'b0;
         rb_addr_R <= '0;
         rb_addr_W <= '0;
         rb_in     <= '0;
         done      <= 1'b0;
         result    <= '0;
         flag_z    <= 1'b0;
         flag_c    <= 1'b0;
         op_q      <= OP_NOP;
         rd_q      <= '0;
         rs2_q     <= '0;
         imm_q     <= '0;
         opa_q     <= '0;
         res_q     <= '0;
         c_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_q      <= in_op;
                  rd_q      <= in_rd;
                  rs2_q     <= in_rs2;
                  imm_q     <= in_imm;
                  rb_addr_R <= in_rs1;
                  in_ready  <= 1'b0;
                  state     <= RD_A;
               end
            end
            RD_A: begin
               rb_addr_R <= rs2_q;
               state     <= RD_B;
            end
            RD_B: begin
               opa_q <= rb_out;
               state <= EXE;
            end
            EXE: begin
               res_q     <= alu_res;
               c_q       <= alu_c;
               rb_addr_W <= rd_q;
               rb_in     <= alu_res;
               rb_ld     <= (op_q != OP_NOP);
               done      <= 1'b1;
               state     <= WB;
            end
            WB: begin
               if (op_q != OP_NOP) begin
                  result <= res_q;
                  flag_z <= (res_q == '0);
                  flag_c <= c_q;
               end
               rb_ld    <= 1'b0;
               done     <= 1'b0;
               in_ready <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// tb/tb_reg_alu_sequencer.sv - scoreboard bench for reg_alu_sequencer with a 4x8 register bank
module tb_reg_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_op;
   logic [1:0] in_rd, in_rs1, in_rs2;
   logic [7:0] in_imm;
   logic [1:0] rb_addr_R, rb_addr_W;
   logic       rb_ld;
   logic [7:0] rb_in;
   logic [7:0] rb_out;
   logic       done;
   logic [7:0] result;
   logic       flag_z, flag_c;

   reg_alu_sequencer #(.DW(8), .AW(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .rb_addr_R(rb_addr_R), .rb_addr_W(rb_addr_W), .rb_ld(rb_ld),
      .rb_in(rb_in), .rb_out(rb_out), .done(done),
      .result(result), .flag_z(flag_z), .flag_c(flag_c)
   );

   always #5 clk = ~clk;

   // Register bank: R0 reads zero, registered read port, write on rb_ld.
   logic [7:0] regs [4];
   initial begin
      for (int i = 0; i < 4; i++) regs[i] = 8'h00;
   end
   always @(posedge clk) begin
      if (rb_ld && rb_addr_W != 2'd0) regs[rb_addr_W] <= rb_in;
      rb_out <= (rb_addr_R == 2'd0) ? 8'h00 : regs[rb_addr_R];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0] op;
      logic [1:0] rd;
      logic [7:0] res;
      logic       z;
      logic       c;
      logic       ld;
      int         hs;
   } item_t;

   item_t      sb[$];
   logic [7:0] mreg [4];
   logic [7:0] m_res;
   logic       m_z, m_c;
   int         last_hs;

   task automatic model_reset();
      m_res = 8'h00;
      m_z   = 1'b0;
      m_c   = 1'b0;
   endtask

   task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [7:0] imm, input bit keep, input bit push);
      item_t      it;
      logic [8:0] w;
      logic [7:0] a, b;
      int         n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("ready_timeout", 0, 1);
      in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      @(posedge clk);
      last_hs = cyc + 1;
      #1;
      if (!keep) in_valid = 1'b0;
      if (push) begin
         a = mreg[rs1];
         b = mreg[rs2];
         w = 9'h000;
         case (op)
            3'b000: w = {1'b0, a} + {1'b0, b};
            3'b001: w = {1'b0, a} - {1'b0, b};
            3'b010: w = {1'b0, a & b};
            3'b011: w = {1'b0, a | b};
            3'b100: w = {1'b0, a ^ b};
            3'b101: w = {1'b0, imm};
            3'b110: w = {1'b0, a};
            default: w = 9'h000;
         endcase
         if (op != 3'b111) begin
            m_res = w[7:0];
            m_z   = (w[7:0] == 8'h00);
            m_c   = w[8];
            if (rd != 2'd0) mreg[rd] = w[7:0];
         end
         it.op = op; it.rd = rd; it.res = m_res; it.z = m_z; it.c = m_c;
         it.ld = (op != 3'b111); it.hs = last_hs;
         sb.push_back(it);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      check(tag, n, 4);
   endtask

   // Scoreboard consumer: WB-cycle outputs, then post-edge result/flags/bank.
   always begin
      item_t it;
      @(negedge clk);
      if (done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            it = sb.pop_front();
            check("done_latency", cyc - it.hs, 3);
            check("wb_rb_ld", rb_ld, it.ld);
            if (it.ld) begin
               check("wb_addr_W", rb_addr_W, it.rd);
               check("wb_rb_in", rb_in, it.res);
            end
            @(negedge clk);
            check("done_pulse_end", done, 0);
            check("rb_ld_after_wb", rb_ld, 0);
            check("result", result, it.res);
            check("flag_z", flag_z, it.z);
            check("flag_c", flag_c, it.c);
            if (it.ld) check("bank_reg", regs[it.rd], (it.rd == 2'd0) ? 8'h00 : it.res);
         end
      end
   end

   initial begin
      int n;
      int hs1;
      rst = 1'b1; in_valid = 1'b0; in_op = 3'b0; in_rd = 2'd0; in_rs1 = 2'd0; in_rs2 = 2'd0; in_imm = 8'h00;
      for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_rb_ld", rb_ld, 0);
      check("rst_addr_R", rb_addr_R, 0);
      check("rst_addr_W", rb_addr_W, 0);
      check("rst_rb_in", rb_in, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_flags", {flag_z, flag_c}, 0);

      issue(3'b101, 2'd1, 2'd0, 2'd0, 8'h05, 0, 1); wait_idle("busy_ldi1");
      issue(3'b101, 2'd2, 2'd0, 2'd0, 8'hFB, 0, 1); wait_idle("busy_ldi2");
      issue(3'b000, 2'd3, 2'd1, 2'd2, 8'h00, 0, 1); wait_idle("busy_add");
      issue(3'b001, 2'd3, 2'd1, 2'd2, 8'h00, 0, 1); wait_idle("busy_sub");

      issue(3'b101, 2'd1, 2'd0, 2'd0, 8'h10, 1, 1);
      hs1 = last_hs;
      issue(3'b110, 2'd2, 2'd1, 2'd0, 8'h00, 0, 1);
      check("b2b_handshake_gap", last_hs - hs1, 5);
      wait_idle("busy_mov");

      issue(3'b101, 2'd0, 2'd0, 2'd0, 8'hAA, 0, 1); wait_idle("busy_ldi_r0");
      issue(3'b110, 2'd1, 2'd0, 2'd0, 8'h00, 0, 1); wait_idle("busy_mov_r0");
      issue(3'b111, 2'd2, 2'd0, 2'd0, 8'h00, 0, 1); wait_idle("busy_nop");

      issue(3'b101, 2'd1, 2'd0, 2'd0, 8'hF0, 0, 1); wait_idle("busy_ldi_f0");
      issue(3'b101, 2'd2, 2'd0, 2'd0, 8'h3C, 0, 1); wait_idle("busy_ldi_3c");
      issue(3'b010, 2'd3, 2'd1, 2'd2, 8'h00, 0, 1); wait_idle("busy_and");
      issue(3'b011, 2'd3, 2'd1, 2'd2, 8'h00, 0, 1); wait_idle("busy_or");
      issue(3'b100, 2'd3, 2'd1, 2'd2, 8'h00, 0, 1); wait_idle("busy_xor");

      // Abort an ADD in EXE: R3 must keep 0x22.
      issue(3'b101, 2'd3, 2'd0, 2'd0, 8'h22, 0, 1); wait_idle("busy_ldi_22");
      issue(3'b000, 2'd3, 2'd1, 2'd2, 8'h00, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("abort_exe_rb_ld", rb_ld, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      @(negedge clk);
      check("abort_in_ready", in_ready, 1);
      check("abort_rb_ld", rb_ld, 0);
      check("abort_done", done, 0);
      check("abort_result", result, 0);
      check("abort_flags", {flag_z, flag_c}, 0);
      check("abort_addr_R", rb_addr_R, 0);
      check("abort_r3_kept", regs[3], 8'h22);
      repeat (3) @(negedge clk);
      check("abort_r3_still", regs[3], 8'h22);

      issue(3'b111, 2'd0, 2'd0, 2'd0, 8'h00, 0, 1); wait_idle("busy_nop2");
      issue(3'b000, 2'd3, 2'd1, 2'd2, 8'h00, 0, 1); wait_idle("busy_add2");

      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard_drained", sb.size(), 0);
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1);
   end

endmodule
